// File: rtl/pm_pkg.sv
// Shared types and constants for the pattern-match engines.
package pm_pkg;

    localparam int unsigned PatW   = 64;
    localparam int unsigned MaxLen = 8;

    localparam int unsigned CtrlOpHi  = 15;
    localparam int unsigned CtrlOpLo  = 14;
    localparam int unsigned CtrlLenHi = 13;
    localparam int unsigned CtrlLenLo = 11;
    localparam int unsigned CtrlNHi   = 10;
    localparam int unsigned CtrlNLo   = 0;

    typedef enum logic [1:0] {
        OpAbort     = 2'b00,
        OpCount     = 2'b01,
        OpFirst     = 2'b10,
        OpCountNovl = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/pm_window_cmp.sv
// Compares the newest L window bytes against pattern bytes L-1..0; purely combinational.
module pm_window_cmp
    import pm_pkg::*;
(
    input  logic [PatW-1:0] window_i,
    input  logic [PatW-1:0] pattern_i,
    input  logic [2:0]      len_m1_i,
    input  logic [3:0]      fill_i,
    output logic            match_o
);

    logic       all_eq;
    logic [2:0] idx;

    always_comb begin
        all_eq = 1'b1;
        idx    = 3'd0;
        for (int unsigned j = 0; j < MaxLen; j++) begin
            if (j <= 32'(len_m1_i)) begin
                // Window byte 0 is the newest, so it pairs with the last pattern byte.
                idx = len_m1_i - 3'(j);
                if (window_i[8*j +: 8] != pattern_i[8*idx +: 8]) begin
                    all_eq = 1'b0;
                end
            end
        end
        match_o = all_eq && (fill_i >= ({1'b0, len_m1_i} + 4'd1));
    end

endmodule

// File: rtl/pattern_match_unit.sv
// Byte-serial pattern matcher: counts/finds an up-to-8-byte pattern in an N-byte stream.
module pattern_match_unit
    import pm_pkg::*;
#(
    parameter int unsigned CntW = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [PatW-1:0] pattern_i,
    input  logic [15:0]     control_i,
    input  logic            s_valid_i,
    input  logic [7:0]      s_data_i,
    output logic            s_ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            found_o,
    output logic [CntW-1:0] match_count_o,
    output logic [CntW-1:0] first_index_o
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [2:0]        len_q, len_d;
    logic [10:0]       n_q, n_d;
    logic [PatW-1:0]   pattern_q, pattern_d;
    logic [PatW-1:0]   window_q, window_d;
    logic [3:0]        fill_q, fill_d;
    logic [10:0]       cnt_q, cnt_d;
    logic              found_q, found_d;
    logic [CntW-1:0]   match_count_q, match_count_d;
    logic [CntW-1:0]   first_index_q, first_index_d;

    logic              accept;
    logic [PatW-1:0]   win_shift;
    logic [3:0]        fill_inc;
    logic              hit;

    assign accept    = s_valid_i && (state_q == StRun);
    assign win_shift = {window_q[PatW-9:0], s_data_i};
    assign fill_inc  = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;

    pm_window_cmp u_cmp (
        .window_i  (win_shift),
        .pattern_i (pattern_q),
        .len_m1_i  (len_q),
        .fill_i    (fill_inc),
        .match_o   (hit)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        len_d         = len_q;
        n_d           = n_q;
        pattern_d     = pattern_q;
        window_d      = window_q;
        fill_d        = fill_q;
        cnt_d         = cnt_q;
        found_d       = found_q;
        match_count_d = match_count_q;
        first_index_d = first_index_q;

        if (load_i) begin
            op_d          = op_e'(control_i[CtrlOpHi:CtrlOpLo]);
            len_d         = control_i[CtrlLenHi:CtrlLenLo];
            n_d           = control_i[CtrlNHi:CtrlNLo];
            pattern_d     = pattern_i;
            window_d      = '0;
            fill_d        = 4'd0;
            cnt_d         = 11'd0;
            found_d       = 1'b0;
            match_count_d = '0;
            first_index_d = '0;
            if (op_d == OpAbort) begin
                state_d = StIdle;
            end else if (n_d == 11'd0) begin
                state_d = StDone;
            end else begin
                state_d = StRun;
            end
        end else if (accept) begin
            window_d = win_shift;
            fill_d   = fill_inc;
            cnt_d    = cnt_q + 11'd1;
            if (hit) begin
                if (match_count_q != '1) begin
                    match_count_d = match_count_q + 1'b1;
                end
                if (!found_q) begin
                    found_d       = 1'b1;
                    // bytes_consumed - L == cnt_q - (L-1)
                    first_index_d = CntW'(cnt_q) - CntW'(len_q);
                end
                if (op_q == OpCountNovl) begin
                    fill_d = 4'd0;
                end
                if (op_q == OpFirst) begin
                    state_d = StDone;
                end
            end
            if (cnt_d == n_q) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            op_q          <= OpAbort;
            len_q         <= 3'd0;
            n_q           <= 11'd0;
            pattern_q     <= '0;
            window_q      <= '0;
            fill_q        <= 4'd0;
            cnt_q         <= 11'd0;
            found_q       <= 1'b0;
            match_count_q <= '0;
            first_index_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            len_q         <= len_d;
            n_q           <= n_d;
            pattern_q     <= pattern_d;
            window_q      <= window_d;
            fill_q        <= fill_d;
            cnt_q         <= cnt_d;
            found_q       <= found_d;
            match_count_q <= match_count_d;
            first_index_q <= first_index_d;
        end
    end

    assign s_ready_o     = (state_q == StRun);
    assign busy_o        = (state_q == StRun);
    assign done_o        = (state_q == StDone);
    assign found_o       = found_q;
    assign match_count_o = match_count_q;
    assign first_index_o = first_index_q;

endmodule

// File: tb/tb_pattern_match_unit.sv
// Directed bench for pattern_match_unit with an expected-result scoreboard queue.
module tb_pattern_match_unit;

    logic        clk;
    logic        reset;
    logic        load;
    logic [63:0] pattern;
    logic [15:0] control;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        found;
    logic [15:0] match_count;
    logic [15:0] first_index;

    typedef struct {
        string       tag;
        logic [15:0] count;
        logic [15:0] first;
        logic        found;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   sent;

    pattern_match_unit #(.CntW(16)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .load_i        (load),
        .pattern_i     (pattern),
        .control_i     (control),
        .s_valid_i     (s_valid),
        .s_data_i      (s_data),
        .s_ready_o     (s_ready),
        .busy_o        (busy),
        .done_o        (done),
        .found_o       (found),
        .match_count_o (match_count),
        .first_index_o (first_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] mkpat(input string s);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < s.len() && i < 8; i++) p[8*i +: 8] = s[i];
        return p;
    endfunction

    // Inputs change on the falling edge; on return we sit just after the capturing edge.
    task automatic do_load(input string pat, input logic [1:0] op, input int l, input int n);
        @(negedge clk);
        load    = 1'b1;
        pattern = mkpat(pat);
        control = {op, 3'(l - 1), 11'(n)};
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic send(input string s, input bit gaps);
        sent = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (!s_ready) break;
            s_valid = 1'b1;
            s_data  = s[i];
            @(negedge clk);
            sent++;
            s_valid = 1'b0;
            if (gaps) @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic push(input string tag, input int c, input int f, input bit fd);
        exp_t e;
        e.tag   = tag;
        e.count = 16'(c);
        e.first = 16'(f);
        e.found = fd;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, "_count"}, 32'(match_count), 32'(e.count));
        chk({e.tag, "_first"}, 32'(first_index), 32'(e.first));
        chk({e.tag, "_found"}, 32'(found), 32'(e.found));
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        pattern = '0;
        control = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_first", 32'(first_index), 0);
        reset = 1'b0;
        @(negedge clk);

        // Overlapping count, match on final byte
        do_load("ab", 2'b01, 2, 6);
        chk("ab_busy", 32'(busy), 1);
        chk("ab_ready", 32'(s_ready), 1);
        chk("ab_cnt0", 32'(match_count), 0);
        push("ab", 3, 0, 1);
        send("ababab", 1'b0);
        chk("ab_done", 32'(done), 1);
        chk("ab_busy_end", 32'(busy), 0);
        chk("ab_ready_end", 32'(s_ready), 0);
        pop_check();

        do_load("aa", 2'b01, 2, 4);
        push("aa_ovl", 3, 0, 1);
        send("aaaa", 1'b0);
        chk("aa_ovl_done", 32'(done), 1);
        pop_check();

        do_load("aa", 2'b11, 2, 4);
        push("aa_novl", 2, 0, 1);
        send("aaaa", 1'b0);
        chk("aa_novl_done", 32'(done), 1);
        pop_check();

        // Find-first stops after byte 4
        do_load("cd", 2'b10, 2, 10);
        push("cd_first", 1, 2, 1);
        send("xxcdcdcdcd", 1'b0);
        chk("cd_sent", sent, 4);
        chk("cd_done", 32'(done), 1);
        chk("cd_ready", 32'(s_ready), 0);
        pop_check();

        do_load("abcdefgh", 2'b01, 8, 7);
        push("l8", 0, 0, 0);
        send("abcdefg", 1'b0);
        chk("l8_done", 32'(done), 1);
        pop_check();

        // Asynchronous reset mid-run
        do_load("ab", 2'b01, 2, 6);
        send("aba", 1'b0);
        chk("pre_rst_count", 32'(match_count), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(s_ready), 0);
        chk("arst_found", 32'(found), 0);
        chk("arst_count", 32'(match_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // Restart mid-run
        do_load("ab", 2'b01, 2, 6);
        send("abab", 1'b0);
        do_load("ab", 2'b01, 2, 4);
        chk("reload_count", 32'(match_count), 0);
        chk("reload_found", 32'(found), 0);
        chk("reload_busy", 32'(busy), 1);
        push("reload", 2, 0, 1);
        send("abab", 1'b0);
        chk("reload_done", 32'(done), 1);
        pop_check();

        // Abort mid-run
        do_load("ab", 2'b01, 2, 6);
        send("ab", 1'b0);
        do_load("ab", 2'b00, 2, 6);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ready", 32'(s_ready), 0);
        chk("abort_count", 32'(match_count), 0);

        // Zero-length stream
        do_load("ab", 2'b01, 2, 0);
        chk("n0_done", 32'(done), 1);
        chk("n0_ready", 32'(s_ready), 0);
        send("ab", 1'b0);
        chk("n0_sent", sent, 0);
        chk("n0_count", 32'(match_count), 0);

        // Stalls must not change the outcome
        do_load("ab", 2'b01, 2, 6);
        push("gaps", 3, 0, 1);
        send("ababab", 1'b1);
        chk("gaps_done", 32'(done), 1);
        pop_check();

        // Load on the same edge as an offered byte drops the byte
        do_load("ab", 2'b01, 2, 2);
        s_valid = 1'b1;
        s_data  = "a";
        do_load("ab", 2'b01, 2, 2);
        s_valid = 1'b0;
        push("ld_win", 1, 0, 1);
        send("ab", 1'b0);
        chk("ld_win_done", 32'(done), 1);
        pop_check();

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pattern_match_unit.md
# pattern_match_unit

Byte-serial pattern matching engine; one instance per PMM slot, directly downstream of the memory-mapped peripheral interface. The interface hands it a 64-bit pattern and a 16-bit control word with a one-cycle `load` pulse. The unit then consumes a byte stream over a valid/ready handshake and reports match count, first-match index and a sticky `done` that the interface exposes as status.

## Interface
- `CNT_W`, 16: width of `match_count` and `first_index`.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle pulse; latches `pattern_in`/`control_in`, (re)starts the unit.
- `pattern_in`  in  64  pattern; byte i = `pattern_in[8i+7:8i]`, byte 0 matched first.
- `control_in`  in  16  [15:14] op, [13:11] pattern length minus 1 (L = 1..8), [10:0] stream length N in bytes.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  unit accepts byte this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  sticky; high in DONE until next `load` or `reset`.
- `found`  out  1  at least one match seen since load.
- `match_count`  out  CNT_W  matches counted.
- `first_index`  out  CNT_W  0-based stream offset of first byte of first match; 0 if none.

## Operation
- Reset values: state IDLE; `s_ready`, `busy`, `done`, `found` = 0; `match_count`, `first_index` = 0; window and fill counter cleared.
- States: IDLE, RUN, DONE.
- `load` with op 00 (abort): any state -> IDLE, all results cleared.
- `load` with op != 00: any state -> RUN, results/window/byte counter cleared. Also valid mid-RUN as an abort-and-restart.
- `load` with N = 0: -> DONE directly, count 0.
- Ops: 01 count overlapping; 10 find-first, stop at first match; 11 count non-overlapping.
- Window: 8-byte shift register, newest byte in [7:0]; fill counter saturates at 8.
- Match on accepted byte: fill (including this byte) >= L and window byte j equals pattern byte L-1-j for j = 0..L-1.
- On match:
  - `match_count` increments, saturating at all-ones.
  - First match only: `found` set, `first_index` = bytes_consumed - L, where bytes_consumed includes the current byte.
  - op 11: fill counter cleared after the match, so the next match needs L fresh bytes.
  - op 10: -> DONE immediately.
- RUN -> DONE when byte N is accepted, or on the first match in op 10. A match on byte N is still counted.
- `s_ready` = 1 only in RUN. Bytes offered in IDLE/DONE are ignored.
- Byte counter width 11 bits; no wrap possible since N <= 2047.

## Timing
- `load` sampled at edge k: state, `s_ready`, `busy` valid from k+1; results read 0 at k+1.
- Byte transfer = `s_valid & s_ready` at an edge. Results reflecting that byte are visible the same edge (registered outputs, 1-cycle latency from the handshake cycle).
- Final byte accepted at edge m: `done` = 1, `busy` = 0, `s_ready` = 0 from m.
- Throughput: one byte per cycle; `s_valid` low stalls with no state change.
- `load` and a byte transfer on the same edge: `load` wins, the byte is dropped.
- `reset` asserted mid-RUN: immediate return to reset values, independent of `clk`.

## Structure
- Shared package `pm_pkg`:
  - op enum (OP_ABORT, OP_COUNT, OP_FIRST, OP_COUNT_NOVL);
  - state enum (IDLE, RUN, DONE);
  - control field bit positions;
  - pattern width 64 and max length 8.
- One natural sub-module `pm_window_cmp`: combinational. Inputs: window, pattern, L, fill. Output: match. Reused by other PMM variants.

## Test plan
- Pattern "ab" (L=2), op 01, N=6, stream "ababab" -> `match_count`=3, `first_index`=0, `done` high the edge after byte 6.
- Pattern "aa", op 01 vs op 11, stream "aaaa" N=4 -> count 3 vs 2.
- Pattern "cd", op 10, N=10, stream "xxcdcd..." -> `done` after byte 4, `first_index`=2, count 1, `s_ready` low thereafter.
- L=8 pattern, N=7 -> no match, `found`=0, count 0, `done` after byte 7.
- Mid-RUN events:
  - `reset` pulse -> all outputs 0 asynchronously.
  - New `load` mid-RUN -> results cleared, fresh count.
  - op 00 `load` -> IDLE, `busy`=0.
- N=0 load -> `done`=1 next cycle, `s_ready` never high; `s_valid` gaps mid-stream -> identical results to gapless run.
